// File: rtl/adc_pingpong_buffer.sv
// adc_pingpong_buffer: ping/pong double-buffered sample store between the ADC
// sequencer (writer) and the host/SPI readout (reader). The writer fills one bank
// while the reader drains the other one. Banks are handed over in fill order.
//
// Optional feature: define ADC_BUF_DROP_CNT_EN to add a saturating 16-bit
// dropped-word counter on output drop_cnt.
module adc_pingpong_buffer #(
    parameter int unsigned  DW    = 32,
    parameter int unsigned  DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          ping_full,
    output logic          pong_full,
    output logic          rd_avail,
    output logic          wr_bank,
    output logic          overflow
`ifdef ADC_BUF_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    localparam logic [AW-1:0] PtrLast = AW'(DEPTH - 1);

    // Sample storage; the upper address bit selects the bank.
    logic [DW-1:0] mem_q [2*DEPTH];

    // Pointer and flag state.
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [1:0]    full_q,    full_d;
    logic          ovf_q,     ovf_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q;

    // Per-cycle decode.
    logic          rd_accept;
    logic          rd_release;
    logic [1:0]    release_vec;
    logic          wr_full_eff;
    logic          wr_accept;
    logic          wr_drop;
    logic          wr_last;
    logic [AW:0]   wr_addr;
    logic [AW:0]   rd_addr;

    assign wr_addr = {wr_bank_q, wr_ptr_q};
    assign rd_addr = {rd_bank_q, rd_ptr_q};

    // Read/write acceptance; a bank released this cycle is writable this cycle.
    always_comb begin
        rd_accept   = ~flush & rd_en & full_q[rd_bank_q];
        rd_release  = rd_accept & (rd_ptr_q == PtrLast);
        release_vec = 2'b00;
        release_vec[rd_bank_q] = rd_release;
        wr_full_eff = full_q[wr_bank_q] & ~release_vec[wr_bank_q];
        wr_accept   = ~flush & wr_en & ~wr_full_eff;
        wr_drop     = ~flush & wr_en & wr_full_eff;
        wr_last     = wr_accept & (wr_ptr_q == PtrLast);
    end

    // Next-state for pointers, bank selects, full flags and status.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        rd_valid_d = 1'b0;

        if (flush) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            full_d    = 2'b00;
            ovf_d     = 1'b0;
        end else begin
            if (rd_accept) begin
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                if (rd_release) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end
            end
            // Release is applied before the fill so both flags update independently.
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_last) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
            if (wr_drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 2'b00;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample write port; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read data; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (flush) begin
            rd_data_q <= '0;
        end else if (rd_accept) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

`ifdef ADC_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of words dropped on a full bank.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = '0;
        end else if (wr_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign ping_full = full_q[0];
    assign pong_full = full_q[1];
    assign rd_avail  = |full_q;
    assign wr_bank   = wr_bank_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adc_pingpong_buffer.sv
// Testbench for adc_pingpong_buffer (DEPTH=4, DW=32): directed vector table,
// hand-written corner sequences and random traffic against a queue-based model.
module tb_adc_pingpong_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          ping_full;
    logic          pong_full;
    logic          rd_avail;
    logic          wr_bank;
    logic          overflow;
`ifdef ADC_BUF_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    adc_pingpong_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ping_full (ping_full),
        .pong_full (pong_full),
        .rd_avail  (rd_avail),
        .wr_bank   (wr_bank),
        .overflow  (overflow)
`ifdef ADC_BUF_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: completed banks are a FIFO of words plus a FIFO of bank ids.
    logic [31:0] m_fill[$];
    logic [31:0] m_rdy_words[$];
    bit          m_rdy_bank[$];
    bit          m_fill_bank;
    int          m_rcnt;
    bit          m_ovf;
    int          m_drop;
    bit          m_rv;
    logic [31:0] m_rdat;

    function automatic void model_reset();
        m_fill.delete();
        m_rdy_words.delete();
        m_rdy_bank.delete();
        m_fill_bank = 0;
        m_rcnt      = 0;
        m_ovf       = 0;
        m_drop      = 0;
        m_rv        = 0;
        m_rdat      = '0;
    endfunction

    function automatic void model_step(input bit fl, input bit we, input logic [31:0] wd,
                                       input bit re);
        if (fl) begin
            model_reset();
            return;
        end
        m_rv = 0;
        if (re && m_rdy_bank.size() > 0) begin
            m_rdat = m_rdy_words.pop_front();
            m_rv   = 1;
            m_rcnt++;
            if (m_rcnt == DEPTH) begin
                void'(m_rdy_bank.pop_front());
                m_rcnt = 0;
            end
        end
        if (we) begin
            // Writer only stalls when both banks are still waiting for readout.
            if (m_rdy_bank.size() == 2) begin
                m_ovf = 1;
                if (m_drop < 16'hFFFF) m_drop++;
            end else begin
                m_fill.push_back(wd);
                if (m_fill.size() == DEPTH) begin
                    foreach (m_fill[k]) m_rdy_words.push_back(m_fill[k]);
                    m_rdy_bank.push_back(m_fill_bank);
                    m_fill_bank = ~m_fill_bank;
                    m_fill.delete();
                end
            end
        end
    endfunction

    function automatic bit model_has(input bit b);
        foreach (m_rdy_bank[k]) if (m_rdy_bank[k] == b) return 1;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data", rd_data, m_rdat);
        chk("ping_full", 32'(ping_full), 32'(model_has(0)));
        chk("pong_full", 32'(pong_full), 32'(model_has(1)));
        chk("rd_avail", 32'(rd_avail), 32'(m_rdy_bank.size() > 0));
        chk("wr_bank", 32'(wr_bank), 32'(m_fill_bank));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ADC_BUF_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // One clock of stimulus; outputs sampled 1 ns after the edge.
    task automatic cycle(input bit fl, input bit we, input logic [31:0] wd, input bit re);
        flush   = fl;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        model_step(fl, we, wd, re);
        #1;
        check_model();
        flush = 0;
        wr_en = 0;
        rd_en = 0;
    endtask

    typedef struct packed {
        logic        fl;
        logic        we;
        logic [31:0] wd;
        logic        re;
        logic        ev;
        logic [31:0] ed;
        logic        ep;
        logic        eq;
        logic        eb;
        logic        eo;
    } vec_t;

    vec_t tbl[24];

    initial begin
        rst = 1; flush = 0; wr_en = 0; wr_data = '0; rd_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid", 32'(rd_valid), 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_avail", 32'(rd_avail), 0);
        chk("reset wr_bank", 32'(wr_bank), 0);
        chk("reset overflow", 32'(overflow), 0);
        rst = 0;

        //              fl we wd           re ev ed      ep eq eb eo
        tbl[0]  = '{1'b0, 1'b1, 32'd1,     1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'd2,     1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'd3,     1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'd4,     1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd1,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd3,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd4,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b0, 32'd4,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'd10,    1'b0, 1'b0, 32'd4,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'd11,    1'b0, 1'b0, 32'd4,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'd12,    1'b0, 1'b0, 32'd4,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'd13,    1'b0, 1'b0, 32'd4,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'd14,    1'b0, 1'b0, 32'd4,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'd15,    1'b0, 1'b0, 32'd4,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 32'd16,    1'b0, 1'b0, 32'd4,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 32'd17,    1'b0, 1'b0, 32'd4,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'hDEAD,  1'b0, 1'b0, 32'd4,  1'b1, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd11, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd13, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 32'd0,     1'b1, 1'b1, 32'd14, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[23] = '{1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        // Directed table: fill/drain ping, empty read, overflow, pong-first drain, flush.
        for (int i = 0; i < 24; i++) begin
            flush = tbl[i].fl; wr_en = tbl[i].we; wr_data = tbl[i].wd; rd_en = tbl[i].re;
            @(posedge clk);
            model_step(tbl[i].fl, tbl[i].we, tbl[i].wd, tbl[i].re);
            #1;
            chk($sformatf("tbl%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].ed);
            chk($sformatf("tbl%0d ping_full", i), 32'(ping_full), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d pong_full", i), 32'(pong_full), 32'(tbl[i].eq));
            chk($sformatf("tbl%0d rd_avail", i), 32'(rd_avail), 32'(tbl[i].ep | tbl[i].eq));
            chk($sformatf("tbl%0d wr_bank", i), 32'(wr_bank), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d overflow", i), 32'(overflow), 32'(tbl[i].eo));
`ifdef ADC_BUF_DROP_CNT_EN
            if (i == 17) chk("tbl17 drop_cnt", 32'(drop_cnt), 1);
            if (i == 23) chk("tbl23 drop_cnt", 32'(drop_cnt), 0);
`endif
        end
        flush = 0; wr_en = 0; rd_en = 0;

        // Release of ping and a write into ping in the same cycle.
        for (int i = 0; i < 8; i++) cycle(0, 1, 32'h100 + 32'(i), 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
        cycle(0, 1, 32'h55, 1);
        chk("sim rd_data", rd_data, 32'h103);
        chk("sim overflow", 32'(overflow), 0);
        chk("sim ping_full", 32'(ping_full), 0);
        chk("sim pong_full", 32'(pong_full), 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);
        chk("sim pong last", rd_data, 32'h107);
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h56 + 32'(i), 0);
        chk("sim ping refull", 32'(ping_full), 1);
        cycle(0, 0, '0, 1);
        chk("sim ping[0]", rd_data, 32'h55);

        // Flush after a partial bank, then a clean fill of ping.
        cycle(1, 0, '0, 0);
        cycle(0, 1, 32'hA1, 0);
        cycle(0, 1, 32'hA2, 0);
        cycle(1, 1, 32'hA3, 1);
        chk("flush wr_bank", 32'(wr_bank), 0);
        chk("flush rd_avail", 32'(rd_avail), 0);
        for (int i = 5; i <= 8; i++) cycle(0, 1, 32'(i), 0);
        chk("flush ping_full", 32'(ping_full), 1);
        for (int i = 5; i <= 8; i++) begin
            cycle(0, 0, '0, 1);
            chk("flush readback", rd_data, 32'(i));
        end

        // Asynchronous reset between clock edges during a write burst.
        cycle(0, 1, 32'hB0, 0);
        cycle(0, 1, 32'hB1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'hB2 + 32'(i), 0);
        cycle(0, 0, '0, 1);
        wr_en = 1; wr_data = 32'hBF;
        #3;
        rst = 1;
        #1;
        chk("async rd_valid", 32'(rd_valid), 0);
        chk("async rd_data", rd_data, 0);
        chk("async ping_full", 32'(ping_full), 0);
        chk("async pong_full", 32'(pong_full), 0);
        chk("async wr_bank", 32'(wr_bank), 0);
        chk("async overflow", 32'(overflow), 0);
        wr_en = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        chk("post-rst rd_avail", 32'(rd_avail), 0);
        check_model();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), $urandom(),
                  ($urandom_range(0, 99) < 45));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
